i2c_target: RTL and testbench

//  7-bit-address I2C target (slave), oversampling SCL/SDA on the system clock. Counterpart of the team's
//  I2C master; used as on-chip register-port responder and as the loopback partner in master testbenches.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_line_sync.sv | 49 ++++
 rtl/i2c_target.sv | 179 +++++++++++++++++
 tb/tb_i2c_target.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and
// the bus-level constants for ACK/NACK and the R/W bit.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_READ  = 1'b1;

    // General call (address 0) is never acknowledged.
    function automatic logic addr_hit(input logic [6:0] addr,
                                      input logic [6:0] own);
        return (addr == own) && (addr != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and event detector for the SCL/SDA pair.
// Ports: clock, arstn; scl_i/sda_i async bus levels; sda = synced SDA;
// scl_rise/scl_fall, start_cond/stop_cond = single-cycle events.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic arstn,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_cond,
    output logic stop_cond
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl;

    // Flops reset high so an idle bus produces no spurious edge.
    always_ff @(posedge clock or negedge arstn) begin
        if (!arstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl = scl_sync[SYNC_STAGES-1];
    assign sda = sda_sync[SYNC_STAGES-1];

    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;

    // SDA moving while SCL stays high is always a bus condition.
    assign start_cond = scl & scl_prev & sda_prev & ~sda;
    assign stop_cond  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target.sv
// 7-bit address I2C target, oversampled on the system clock.
// Ports: clock, arstn; scl_i/sda_i bus in; sda_oe pull-low; rx_data/
// rx_valid write bytes; tx_req/tx_data read bytes; start_det/stop_det/busy.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       arstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_cond;
    logic       stop_cond;

    i2c_state_e state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       rw;
    // Set on the 8th rise of a byte, or on a sampled ACK in RD_ACK;
    // the following SCL fall acts on it.
    logic       pend;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock     (clock),
        .arstn     (arstn),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_cond(start_cond),
        .stop_cond (stop_cond)
    );

    always_ff @(posedge clock or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            rw        <= 1'b0;
            pend      <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            if (start_cond) begin
                state     <= ST_ADDR;
                bit_cnt   <= 3'd0;
                pend      <= 1'b0;
                sda_oe    <= 1'b0;
                start_det <= 1'b1;
                busy      <= 1'b1;
            end else if (stop_cond) begin
                state    <= ST_IDLE;
                bit_cnt  <= 3'd0;
                pend     <= 1'b0;
                sda_oe   <= 1'b0;
                stop_det <= 1'b1;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ST_ADDR, ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                pend <= 1'b1;
                        end else if (scl_fall && pend) begin
                            pend    <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (state == ST_WR_DATA) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                sda_oe   <= 1'b1;
                                state    <= ST_WR_ACK;
                            end else if (addr_hit(shreg[7:1], TARGET_ADDR)) begin
                                rw     <= shreg[0];
                                sda_oe <= 1'b1;
                                tx_req <= (shreg[0] == RW_READ);
                                state  <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (rw == RW_READ) begin
                                shreg  <= tx_data;
                                sda_oe <= ~tx_data[7];
                                state  <= ST_RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                pend <= 1'b1;
                        end else if (scl_fall) begin
                            if (pend) begin
                                pend    <= 1'b0;
                                bit_cnt <= 3'd0;
                                sda_oe  <= 1'b0;
                                state   <= ST_RD_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda == I2C_ACK) begin
                                pend   <= 1'b1;
                                tx_req <= 1'b1;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && pend) begin
                            pend    <= 1'b0;
                            bit_cnt <= 3'd0;
                            shreg   <= tx_data;
                            sda_oe  <= ~tx_data[7];
                            state   <= ST_RD_DATA;
                        end
                    end
                    ST_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                        pend   <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: behavioural I2C master on a wired-AND bus,
// pulse monitors, and a transaction-level expectation model.
module tb_i2c_target;

    localparam time Q = 625ns;

    logic       clock = 1'b0;
    logic       arstn;
    logic       m_scl;
    logic       m_sda;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       start_det;
    logic       stop_det;
    logic       busy;
    logic       bus_sda;

    int checks = 0;
    int errors = 0;

    int          rx_cnt;
    int          tx_cnt;
    int          st_cnt;
    int          sp_cnt;
    logic [7:0]  rx_q[$];
    logic [7:0]  rd_q[$];

    assign bus_sda = ~sda_oe & m_sda;

    always #5ns clock = ~clock;

    i2c_target dut (
        .clock    (clock),
        .arstn    (arstn),
        .scl_i    (m_scl),
        .sda_i    (bus_sda),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .start_det(start_det),
        .stop_det (stop_det),
        .busy     (busy)
    );

    always @(negedge clock) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_q.push_back(rx_data);
        end
        if (tx_req) begin
            tx_cnt++;
            tx_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
        end
        if (start_det) st_cnt++;
        if (stop_det)  sp_cnt++;
    end

    task automatic clr_mon();
        rx_cnt = 0;
        tx_cnt = 0;
        st_cnt = 0;
        sp_cnt = 0;
        rx_q.delete();
        rd_q.delete();
    endtask

    task automatic m_start();
        m_sda = 1'b1;
        m_scl = 1'b1;
        #Q;
        m_sda = 1'b0;
        #Q;
        m_scl = 1'b0;
        #Q;
    endtask

    task automatic m_rstart();
        m_sda = 1'b1;
        #Q;
        m_scl = 1'b1;
        #Q;
        m_sda = 1'b0;
        #Q;
        m_scl = 1'b0;
        #Q;
    endtask

    task automatic m_stop();
        m_sda = 1'b0;
        #Q;
        m_scl = 1'b1;
        #Q;
        m_sda = 1'b1;
        #Q;
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sda = b;
        #Q;
        m_scl = 1'b1;
        #Q;
        s = bus_sda;
        #Q;
        m_scl = 1'b0;
        #Q;
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--)
            m_bit(d[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic m_rbyte(input logic ack_in, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(ack_in, s);
    endtask

    task automatic test_reset();
        if ({sda_oe, busy, rx_valid, tx_req, start_det, stop_det} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {sda_oe, busy, rx_valid, tx_req, start_det, stop_det});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data got %h want 00", rx_data);
        end
        checks++;
    endtask

    task automatic test_write();
        logic a0, a1;
        clr_mon();
        m_start();
        m_wbyte(8'hA0, a0);
        m_wbyte(8'h3C, a1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy got %b want 1", busy);
        end
        m_stop();
        #100ns;
        checks++;
        if ({a0, a1} !== 2'b00) begin
            errors++;
            $display("FAIL wr_acks got %b want 00", {a0, a1});
        end
        checks++;
        if (rx_cnt !== 1 || rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL wr_rx got cnt=%0d data=%h want cnt=1 data=3c",
                     rx_cnt, rx_data);
        end
        checks++;
        if (sp_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_stop got stops=%0d busy=%b want 1 0", sp_cnt, busy);
        end
    endtask

    task automatic test_nack();
        logic a0, a1;
        clr_mon();
        m_start();
        m_wbyte(8'hA2, a0);
        m_wbyte(8'h00, a1);
        checks++;
        if ({a0, a1} !== 2'b11 || rx_cnt !== 0) begin
            errors++;
            $display("FAIL nack got acks=%b rx=%0d want 11 0", {a0, a1}, rx_cnt);
        end
        checks++;
        if (busy !== 1'b1 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL nack_wait got busy=%b oe=%b want 1 0", busy, sda_oe);
        end
        m_stop();
        #100ns;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nack_stop got busy=%b want 0", busy);
        end
    endtask

    task automatic test_read();
        logic       a;
        logic [7:0] d0, d1;
        clr_mon();
        rd_q.push_back(8'h96);
        rd_q.push_back(8'h5A);
        m_start();
        m_wbyte(8'hA1, a);
        m_rbyte(1'b0, d0);
        m_rbyte(1'b1, d1);
        checks++;
        if (a !== 1'b0 || d0 !== 8'h96 || d1 !== 8'h5A) begin
            errors++;
            $display("FAIL rd_bytes got ack=%b %h %h want 0 96 5a", a, d0, d1);
        end
        checks++;
        if (tx_cnt !== 2 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_req got req=%0d oe=%b want 2 0", tx_cnt, sda_oe);
        end
        m_stop();
        #100ns;
    endtask

    task automatic test_rstart();
        logic       a0, a1, a2;
        logic [7:0] d, exp_d;
        clr_mon();
        exp_d = 8'($urandom);
        rd_q.push_back(exp_d);
        m_start();
        m_wbyte(8'hA0, a0);
        m_wbyte(8'h11, a1);
        m_rstart();
        checks++;
        if (st_cnt !== 2 || busy !== 1'b1 || sp_cnt !== 0) begin
            errors++;
            $display("FAIL rs_start got starts=%0d busy=%b stops=%0d want 2 1 0",
                     st_cnt, busy, sp_cnt);
        end
        m_wbyte(8'hA1, a2);
        m_rbyte(1'b1, d);
        checks++;
        if ({a0, a1, a2} !== 3'b000 || rx_data !== 8'h11 || d !== exp_d) begin
            errors++;
            $display("FAIL rs_xfer got acks=%b rx=%h rd=%h want 000 11 %h",
                     {a0, a1, a2}, rx_data, d, exp_d);
        end
        m_stop();
        #100ns;
    endtask

    task automatic test_partial_stop();
        logic a, s;
        clr_mon();
        m_start();
        m_wbyte(8'hA0, a);
        for (int i = 0; i < 4; i++)
            m_bit(1'($urandom), s);
        m_stop();
        #100ns;
        checks++;
        if (a !== 1'b0 || rx_cnt !== 0 || sda_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL partial got ack=%b rx=%0d oe=%b busy=%b want 0 0 0 0",
                     a, rx_cnt, sda_oe, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic a;
        clr_mon();
        rd_q.push_back(8'h00);
        m_start();
        m_wbyte(8'hA1, a);
        #Q;
        checks++;
        if (sda_oe !== 1'b1) begin
            errors++;
            $display("FAIL rstm_drive got oe=%b want 1", sda_oe);
        end
        #3ns;
        arstn = 1'b0;
        #1ns;
        checks++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstm_async got oe=%b busy=%b want 0 0", sda_oe, busy);
        end
        m_scl = 1'b1;
        m_sda = 1'b1;
        #100ns;
        arstn = 1'b1;
        #100ns;
        m_start();
        m_wbyte(8'hA0, a);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL rstm_after got ack=%b want 0", a);
        end
        m_stop();
        #100ns;
    endtask

    // Reference: a byte is acknowledged iff the address field equals
    // 0x50; then written bytes appear in order, read bytes come back.
    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [6:0] addr;
            logic       rd, a, exp_a;
            int         n;
            logic [7:0] wr[$];
            logic [7:0] d;
            clr_mon();
            addr  = ($urandom_range(0, 1) == 0) ? 7'h50 : 7'($urandom);
            rd    = 1'($urandom);
            n     = $urandom_range(1, 3);
            exp_a = (addr == 7'h50) ? 1'b0 : 1'b1;
            m_start();
            m_wbyte({addr, rd}, a);
            checks++;
            if (a !== exp_a) begin
                errors++;
                $display("FAIL rnd_addr a=%h got %b want %b", addr, a, exp_a);
            end
            if (rd && !exp_a) begin
                for (int k = 0; k < n; k++) wr.push_back(8'($urandom));
                foreach (wr[k]) rd_q.push_back(wr[k]);
                for (int k = 0; k < n; k++) begin
                    m_rbyte((k == n - 1) ? 1'b1 : 1'b0, d);
                    checks++;
                    if (d !== wr[k]) begin
                        errors++;
                        $display("FAIL rnd_rd[%0d] got %h want %h", k, d, wr[k]);
                    end
                end
            end else if (!rd) begin
                for (int k = 0; k < n; k++) begin
                    wr.push_back(8'($urandom));
                    m_wbyte(wr[k], a);
                    checks++;
                    if (a !== exp_a) begin
                        errors++;
                        $display("FAIL rnd_wack[%0d] got %b want %b", k, a, exp_a);
                    end
                end
            end
            m_stop();
            #100ns;
            if (!rd) begin
                checks++;
                if (exp_a == 1'b0 ? (rx_q != wr) : (rx_q.size() != 0)) begin
                    errors++;
                    $display("FAIL rnd_rx got %0d bytes want %0d",
                             rx_q.size(), exp_a ? 0 : n);
                end
            end
        end
    endtask

    initial begin
        arstn   = 1'b0;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        tx_data = 8'h00;
        clr_mon();
        #50ns;
        test_reset();
        arstn = 1'b1;
        #100ns;
        test_write();
        test_nack();
        test_read();
        test_rstart();
        test_partial_stop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
